// File: rtl/ervp_tcu_entry_scheduler.sv
// TCU remap-table owner: round-robin alloc/free arbitration, commits gated on tcu_idle.
// Optional alloc overlap rejection: define TCU_ENTRY_OVERLAP_CHECK_EN.
module ervp_tcu_entry_scheduler #(
  parameter int BW_ADDR = 32,
  parameter int NUM_TC  = 8,
  parameter int NUM_REQ = 4,
  localparam int BW_IDX = (NUM_TC > 1) ? $clog2(NUM_TC) : 1
) (
  input  logic                       clk,
  input  logic                       rstnn,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0]         req_op,
  input  logic [NUM_REQ*BW_ADDR-1:0] req_base,
  input  logic [NUM_REQ*BW_ADDR-1:0] req_size,
  input  logic [NUM_REQ*BW_ADDR-1:0] req_target,
  input  logic [NUM_REQ*BW_IDX-1:0]  req_idx,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic                       rsp_err,
  output logic [BW_IDX-1:0]          rsp_idx,
  input  logic                       tcu_idle,
  output logic [NUM_TC*BW_ADDR-1:0]  tc_base,
  output logic [NUM_TC*BW_ADDR-1:0]  tc_size,
  output logic [NUM_TC*BW_ADDR-1:0]  tc_target,
  output logic [NUM_TC-1:0]          tc_valid
);

  localparam int BW_REQ = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t state, state_next;

  logic [BW_REQ-1:0]  rr_ptr;
  logic [BW_REQ-1:0]  grant_idx;
  logic [BW_REQ-1:0]  cand_idx;
  logic               grant_found;
  logic               handshake;

  logic               l_op;
  logic [BW_ADDR-1:0] l_base;
  logic [BW_ADDR-1:0] l_size;
  logic [BW_ADDR-1:0] l_target;
  logic [BW_IDX-1:0]  l_idx;
  logic [BW_REQ-1:0]  l_g;

  logic [BW_ADDR-1:0] t_base   [NUM_TC];
  logic [BW_ADDR-1:0] t_size   [NUM_TC];
  logic [BW_ADDR-1:0] t_target [NUM_TC];
  logic [BW_REQ-1:0]  t_owner  [NUM_TC];
  logic [NUM_TC-1:0]  t_valid;

  logic               free_found;
  logic [BW_IDX-1:0]  free_idx;
  logic [BW_ADDR:0]   req_end;
  logic               end_wrap;
  logic               overlap;
  logic               idx_oob;
  logic               alloc_err;
  logic               free_err;
  logic               err;
  logic [BW_IDX-1:0]  eval_idx;
  logic               commit;

  // Round-robin search starting at rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand_idx = BW_REQ'((32'(rr_ptr) + k) % NUM_REQ);
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      l_op     <= 1'b0;
      l_base   <= '0;
      l_size   <= '0;
      l_target <= '0;
      l_idx    <= '0;
      l_g      <= '0;
    end else if (handshake) begin
      l_op     <= req_op[grant_idx];
      l_base   <= req_base[grant_idx*BW_ADDR +: BW_ADDR];
      l_size   <= req_size[grant_idx*BW_ADDR +: BW_ADDR];
      l_target <= req_target[grant_idx*BW_ADDR +: BW_ADDR];
      l_idx    <= req_idx[grant_idx*BW_IDX +: BW_IDX];
      l_g      <= grant_idx;
    end
  end

  // Latched request checked against the live table every WAIT cycle.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = 0; i < NUM_TC; i++) begin
      if (!free_found && !t_valid[i]) begin
        free_found = 1'b1;
        free_idx   = BW_IDX'(i);
      end
    end
    req_end  = {1'b0, l_base} + {1'b0, l_size};
    end_wrap = req_end[BW_ADDR] && (req_end[BW_ADDR-1:0] != '0);
    overlap  = 1'b0;
`ifdef TCU_ENTRY_OVERLAP_CHECK_EN
    for (int unsigned i = 0; i < NUM_TC; i++) begin
      if (t_valid[i] &&
          ({1'b0, l_base} < ({1'b0, t_base[i]} + {1'b0, t_size[i]})) &&
          ({1'b0, t_base[i]} < req_end))
        overlap = 1'b1;
    end
`endif
    idx_oob   = (32'(l_idx) >= NUM_TC);
    alloc_err = !free_found || (l_size == '0) || end_wrap || overlap;
    free_err  = idx_oob || !t_valid[l_idx] || (t_owner[l_idx] != l_g);
    err       = l_op ? free_err : alloc_err;
    eval_idx  = l_op ? l_idx : free_idx;
    commit    = (state == S_WAIT) && !err && tcu_idle;
  end

  always_comb begin
    state_next = state;
    req_ready  = '0;
    rsp_valid  = '0;
    handshake  = 1'b0;
    case (state)
      S_IDLE: begin
        if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          handshake            = 1'b1;
          state_next           = S_WAIT;
        end
      end
      S_WAIT: begin
        if (err || tcu_idle) state_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid[l_g] = 1'b1;
        state_next     = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state   <= S_IDLE;
      rr_ptr  <= '0;
      rsp_err <= 1'b0;
      rsp_idx <= '0;
    end else begin
      state <= state_next;
      if (state == S_WAIT && state_next == S_RESP) begin
        rsp_err <= err;
        rsp_idx <= eval_idx;
      end else if (state == S_RESP) begin
        rsp_err <= 1'b0;
        rsp_idx <= '0;
        rr_ptr  <= (32'(l_g) == NUM_REQ - 1) ? '0 : l_g + 1'b1;
      end
    end
  end

  // Free clears only the valid bit; region fields are left as they were.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      t_valid <= '0;
      for (int unsigned i = 0; i < NUM_TC; i++) begin
        t_base[i]   <= '0;
        t_size[i]   <= '0;
        t_target[i] <= '0;
        t_owner[i]  <= '0;
      end
    end else if (commit) begin
      if (l_op) begin
        t_valid[l_idx] <= 1'b0;
      end else begin
        t_valid[free_idx]  <= 1'b1;
        t_base[free_idx]   <= l_base;
        t_size[free_idx]   <= l_size;
        t_target[free_idx] <= l_target;
        t_owner[free_idx]  <= l_g;
      end
    end
  end

  always_comb begin
    tc_base   = '0;
    tc_size   = '0;
    tc_target = '0;
    for (int unsigned i = 0; i < NUM_TC; i++) begin
      tc_base[i*BW_ADDR +: BW_ADDR]   = t_base[i];
      tc_size[i*BW_ADDR +: BW_ADDR]   = t_size[i];
      tc_target[i*BW_ADDR +: BW_ADDR] = t_target[i];
    end
    tc_valid = t_valid;
  end

endmodule

// File: tb/tb_ervp_tcu_entry_scheduler.sv
// Scoreboard bench for ervp_tcu_entry_scheduler: expected responses queued at handshake, checked on rsp_valid.
module tb_ervp_tcu_entry_scheduler;

  localparam int BW_ADDR = 32;
  localparam int NUM_TC  = 8;
  localparam int NUM_REQ = 4;
  localparam int BW_IDX  = 3;

  logic                       clk;
  logic                       rstnn;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ-1:0]         req_op;
  logic [NUM_REQ*BW_ADDR-1:0] req_base;
  logic [NUM_REQ*BW_ADDR-1:0] req_size;
  logic [NUM_REQ*BW_ADDR-1:0] req_target;
  logic [NUM_REQ*BW_IDX-1:0]  req_idx;
  logic [NUM_REQ-1:0]         rsp_valid;
  logic                       rsp_err;
  logic [BW_IDX-1:0]          rsp_idx;
  logic                       tcu_idle;
  logic [NUM_TC*BW_ADDR-1:0]  tc_base;
  logic [NUM_TC*BW_ADDR-1:0]  tc_size;
  logic [NUM_TC*BW_ADDR-1:0]  tc_target;
  logic [NUM_TC-1:0]          tc_valid;

  ervp_tcu_entry_scheduler #(
    .BW_ADDR(BW_ADDR),
    .NUM_TC (NUM_TC),
    .NUM_REQ(NUM_REQ)
  ) dut (
    .clk       (clk),
    .rstnn     (rstnn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_base  (req_base),
    .req_size  (req_size),
    .req_target(req_target),
    .req_idx   (req_idx),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_idx   (rsp_idx),
    .tcu_idle  (tcu_idle),
    .tc_base   (tc_base),
    .tc_size   (tc_size),
    .tc_target (tc_target),
    .tc_valid  (tc_valid)
  );

  typedef struct {
    int          g;
    logic        err;
    logic [2:0]  idx;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   errors   = 0;
  int   checks   = 0;
  int   rsp_seen = 0;
  int   cyc      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid !== 4'b0000) begin
        rsp_seen++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: rsp_valid=%b, required no response", rsp_valid);
        end else begin
          e = sb.pop_front();
          if (rsp_valid !== (4'b0001 << e.g) || rsp_err !== e.err || rsp_idx !== e.idx) begin
            errors++;
            $display("FAIL rsp: got valid=%b err=%b idx=%0d, required valid=%b err=%b idx=%0d",
                     rsp_valid, rsp_err, rsp_idx, 4'b0001 << e.g, e.err, e.idx);
          end
          if (e.cyc != 0) begin
            checks++;
            if (cyc != e.cyc) begin
              errors++;
              $display("FAIL rsp_latency: got cycle %0d, required cycle %0d", cyc, e.cyc);
            end
          end
        end
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rstnn      = 1'b0;
    req_valid  = '0;
    req_op     = '0;
    req_base   = '0;
    req_size   = '0;
    req_target = '0;
    req_idx    = '0;
    tcu_idle   = 1'b1;
    repeat (2) @(negedge clk);
    rstnn = 1'b1;
    sb.delete();
  endtask

  task automatic issue(input int r, input logic op, input logic [31:0] base, input logic [31:0] size,
                       input logic [31:0] tgt, input logic [2:0] idx, input logic eerr,
                       input logic [2:0] eidx, input bit timed);
    int   n;
    exp_t e;
    @(negedge clk);
    req_valid[r]              = 1'b1;
    req_op[r]                 = op;
    req_base[r*BW_ADDR +: 32] = base;
    req_size[r*BW_ADDR +: 32] = size;
    req_target[r*BW_ADDR +: 32] = tgt;
    req_idx[r*BW_IDX +: 3]    = idx;
    #1;
    n = 0;
    while (req_ready[r] !== 1'b1 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (req_ready[r] !== 1'b1) begin
      errors++;
      $display("FAIL handshake_timeout: req_ready=%b, required bit %0d set", req_ready, r);
      req_valid[r] = 1'b0;
    end else begin
      e.g   = r;
      e.err = eerr;
      e.idx = eidx;
      e.cyc = timed ? cyc + 2 : 0;
      sb.push_back(e);
      @(negedge clk);
      req_valid[r] = 1'b0;
    end
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      #2;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL rsp_timeout: %0d responses outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_req(input int r, input logic op, input logic [31:0] base, input logic [31:0] size,
                        input logic [31:0] tgt, input logic [2:0] idx, input logic eerr,
                        input logic [2:0] eidx);
    issue(r, op, base, size, tgt, idx, eerr, eidx, 1'b1);
    wait_rsp();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rstnn = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_err, rsp_idx, tc_valid} !== '0 ||
        tc_base !== '0 || tc_size !== '0 || tc_target !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b rsp=%b err=%b idx=%0d valid=%h, required all 0",
               req_ready, rsp_valid, rsp_err, rsp_idx, tc_valid);
    end
    apply_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({req_ready, rsp_valid, tc_valid} !== '0) begin
      errors++;
      $display("FAIL reset_idle: ready=%b rsp=%b valid=%h, required 0", req_ready, rsp_valid, tc_valid);
    end
  endtask

  task automatic test_single_alloc();
    apply_reset();
    do_req(0, 1'b0, 32'h1000, 32'h100, 32'h8000, 3'd0, 1'b0, 3'd0);
    checks++;
    if (tc_valid !== 8'h01 || tc_base[31:0] !== 32'h1000 || tc_size[31:0] !== 32'h100 ||
        tc_target[31:0] !== 32'h8000) begin
      errors++;
      $display("FAIL single_alloc_table: valid=%h base=%h size=%h tgt=%h, required 01/1000/100/8000",
               tc_valid, tc_base[31:0], tc_size[31:0], tc_target[31:0]);
    end
  endtask

  task automatic test_fill();
    apply_reset();
    for (int k = 0; k < 8; k++)
      do_req(1, 1'b0, 32'(k) * 32'h10000, 32'h100, 32'h80000 + 32'(k) * 32'h100, 3'd0, 1'b0, 3'(k));
    do_req(1, 1'b0, 32'h900000, 32'h100, 32'h0, 3'd0, 1'b1, 3'd0);
    checks++;
    if (tc_valid !== 8'hFF || tc_base[7*32 +: 32] !== 32'h70000 || tc_target[7*32 +: 32] !== 32'h80700) begin
      errors++;
      $display("FAIL fill_table: valid=%h base7=%h tgt7=%h, required ff/70000/80700",
               tc_valid, tc_base[7*32 +: 32], tc_target[7*32 +: 32]);
    end
  endtask

  task automatic test_free_ownership();
    int         nine;
    logic [2:0] idx9;
    nine = 9;
    idx9 = nine[2:0];
    apply_reset();
    do_req(0, 1'b0, 32'h1000, 32'h100, 32'h8000, 3'd0, 1'b0, 3'd0);
    do_req(1, 1'b1, 32'h0, 32'h0, 32'h0, 3'd0, 1'b1, 3'd0);
    checks++;
    if (tc_valid !== 8'h01) begin
      errors++;
      $display("FAIL free_wrong_owner: valid=%h, required 01", tc_valid);
    end
    do_req(0, 1'b1, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 3'd0);
    checks++;
    if (tc_valid !== 8'h00 || tc_base[31:0] !== 32'h1000 || tc_target[31:0] !== 32'h8000) begin
      errors++;
      $display("FAIL free_owner: valid=%h base=%h tgt=%h, required 00/1000/8000",
               tc_valid, tc_base[31:0], tc_target[31:0]);
    end
    do_req(0, 1'b1, 32'h0, 32'h0, 32'h0, idx9, 1'b1, idx9);
  endtask

  task automatic test_arith();
    apply_reset();
    do_req(2, 1'b0, 32'hFFFF_FF00, 32'h100, 32'h4000, 3'd0, 1'b0, 3'd0);
    do_req(2, 1'b0, 32'hFFFF_FF00, 32'h101, 32'h4000, 3'd0, 1'b1, 3'd1);
    do_req(2, 1'b0, 32'hFFFF_FFFF, 32'h2, 32'h4000, 3'd0, 1'b1, 3'd1);
    checks++;
    if (tc_valid !== 8'h01) begin
      errors++;
      $display("FAIL arith_table: valid=%h, required 01", tc_valid);
    end
  endtask

  task automatic test_idle_gating();
    int c;
    apply_reset();
    tcu_idle = 1'b0;
    issue(3, 1'b0, 32'h2000, 32'h40, 32'h9000, 3'd0, 1'b0, 3'd0, 1'b0);
    repeat (20) @(negedge clk);
    #2;
    checks++;
    if (sb.size() != 1 || tc_valid !== 8'h00) begin
      errors++;
      $display("FAIL idle_hold: pending=%0d valid=%h, required 1/00", sb.size(), tc_valid);
    end
    @(negedge clk);
    c = cyc;
    sb[0].cyc = c + 1;
    tcu_idle = 1'b1;
    wait_rsp();
    checks++;
    if (tc_valid !== 8'h01 || tc_base[31:0] !== 32'h2000) begin
      errors++;
      $display("FAIL idle_commit: valid=%h base=%h, required 01/2000", tc_valid, tc_base[31:0]);
    end
    tcu_idle = 1'b0;
    do_req(3, 1'b0, 32'h3000, 32'h0, 32'h0, 3'd0, 1'b1, 3'd1);
    tcu_idle = 1'b1;
  endtask

  task automatic test_fairness();
    int   exp_g;
    int   grants;
    int   prev;
    exp_t e;
    apply_reset();
    @(negedge clk);
    for (int r = 0; r < NUM_REQ; r++) begin
      req_op[r]               = 1'b1;
      req_idx[r*BW_IDX +: 3]  = 3'(r + 2);
    end
    req_valid = 4'hF;
    exp_g  = 0;
    grants = 0;
    prev   = -1;
    for (int n = 0; n < 40 && grants < 5; n++) begin
      #1;
      if (req_ready !== 4'b0000) begin
        checks++;
        if (req_ready !== (4'b0001 << exp_g)) begin
          errors++;
          $display("FAIL rr_grant: req_ready=%b, required %b", req_ready, 4'b0001 << exp_g);
        end
        if (prev >= 0) begin
          checks++;
          if (cyc - prev != 3) begin
            errors++;
            $display("FAIL rr_spacing: got %0d cycles, required 3", cyc - prev);
          end
        end
        prev  = cyc;
        e.g   = exp_g;
        e.err = 1'b1;
        e.idx = 3'(exp_g + 2);
        e.cyc = cyc + 2;
        sb.push_back(e);
        exp_g = (exp_g + 1) % NUM_REQ;
        grants++;
      end
      @(negedge clk);
    end
    req_valid = '0;
    checks++;
    if (grants != 5) begin
      errors++;
      $display("FAIL rr_count: got %0d grants, required 5", grants);
    end
    wait_rsp();
  endtask

  task automatic test_overlap();
    apply_reset();
    do_req(0, 1'b0, 32'h1000, 32'h100, 32'h8000, 3'd0, 1'b0, 3'd0);
`ifdef TCU_ENTRY_OVERLAP_CHECK_EN
    do_req(1, 1'b0, 32'h10F0, 32'h20, 32'hA000, 3'd0, 1'b1, 3'd1);
    do_req(1, 1'b0, 32'h1100, 32'h10, 32'hB000, 3'd0, 1'b0, 3'd1);
`else
    do_req(1, 1'b0, 32'h10F0, 32'h20, 32'hA000, 3'd0, 1'b0, 3'd1);
    do_req(1, 1'b0, 32'h1100, 32'h10, 32'hB000, 3'd0, 1'b0, 3'd2);
`endif
    checks++;
`ifdef TCU_ENTRY_OVERLAP_CHECK_EN
    if (tc_valid !== 8'h03) begin
      errors++;
      $display("FAIL overlap_table: valid=%h, required 03", tc_valid);
    end
`else
    if (tc_valid !== 8'h07) begin
      errors++;
      $display("FAIL overlap_table: valid=%h, required 07", tc_valid);
    end
`endif
  endtask

  task automatic test_reset_in_wait();
    int seen0;
    int n;
    apply_reset();
    tcu_idle = 1'b0;
    @(negedge clk);
    req_valid[0]          = 1'b1;
    req_op[0]             = 1'b0;
    req_base[31:0]        = 32'h5000;
    req_size[31:0]        = 32'h80;
    req_target[31:0]      = 32'hC000;
    #1;
    n = 0;
    while (req_ready[0] !== 1'b1 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (req_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL rst_wait_handshake: req_ready=%b, required bit 0", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    seen0 = rsp_seen;
    #2;
    rstnn = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_err, rsp_idx, tc_valid} !== '0 || tc_base !== '0) begin
      errors++;
      $display("FAIL rst_wait_outputs: ready=%b rsp=%b valid=%h, required all 0",
               req_ready, rsp_valid, tc_valid);
    end
    @(negedge clk);
    rstnn    = 1'b1;
    tcu_idle = 1'b1;
    repeat (6) @(negedge clk);
    #2;
    checks++;
    if (rsp_seen != seen0 || tc_valid !== 8'h00) begin
      errors++;
      $display("FAIL rst_wait_dropped: rsps=%0d valid=%h, required 0/00", rsp_seen - seen0, tc_valid);
    end
  endtask

  initial begin
    rstnn      = 1'b0;
    req_valid  = '0;
    req_op     = '0;
    req_base   = '0;
    req_size   = '0;
    req_target = '0;
    req_idx    = '0;
    tcu_idle   = 1'b1;
    fork
      monitor();
      begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
      end
    join_none
    test_reset();
    test_single_alloc();
    test_fill();
    test_free_ownership();
    test_arith();
    test_idle_gating();
    test_fairness();
    test_overlap();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
